// File: rtl/adc_intf_pkg.sv
// rtl/adc_intf_pkg.sv - shared decimation encodings and lane saturation helpers
// Imported by the ADC decimate/gain/buffer block and its sub-modules.
package adc_intf_pkg;

  typedef enum logic [1:0] {
    DECIM_BY_1 = 2'd0,
    DECIM_BY_2 = 2'd1,
    DECIM_BY_4 = 2'd2,
    DECIM_BY_8 = 2'd3
  } decim_sel_e;

  localparam int DECIM_CNT_WIDTH = 3;
  localparam int GAIN_SHIFT_MAX  = 7;

  // Last counter value before wrap, i.e. N-1 for the selected factor N.
  function automatic logic [DECIM_CNT_WIDTH-1:0] decim_last(input logic [1:0] sel);
    logic [DECIM_CNT_WIDTH-1:0] last;
    case (decim_sel_e'(sel))
      DECIM_BY_1: last = 3'd0;
      DECIM_BY_2: last = 3'd1;
      DECIM_BY_4: last = 3'd3;
      DECIM_BY_8: last = 3'd7;
      default:    last = 3'd0;
    endcase
    return last;
  endfunction

  function automatic longint sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/adc_decim_gain_buf_if.sv
// rtl/adc_decim_gain_buf_if.sv - sample input stream and buffered output stream
// master drives samples and consumes the buffer head; slave is the datapath.
interface adc_decim_gain_buf_if #(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int NUM_CH        = 2
);
  localparam int DATA_W = 2 * NUM_CH * IQ_DATA_WIDTH;

  logic [DATA_W-1:0] adc_data;
  logic              adc_valid;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_ready;

  modport master (
    output adc_data,
    output adc_valid,
    output data_out_ready,
    input  data_out,
    input  data_out_valid
  );

  modport slave (
    input  adc_data,
    input  adc_valid,
    input  data_out_ready,
    output data_out,
    output data_out_valid
  );

endinterface

// File: rtl/adc_sync_fifo.sv
// rtl/adc_sync_fifo.sv - single-clock first-word-fall-through sample buffer
// Head is presented combinationally from storage; no write-to-read bypass.
module adc_sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_tdata,
  input  logic                    s_tvalid,
  output logic                    s_drop,
  output logic [DATA_WIDTH-1:0]   m_tdata,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  empty, full, push, pop;

  // A full buffer still accepts a write when the head leaves in the same cycle.
  always_comb begin
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    pop      = !empty && m_tready;
    push     = s_tvalid && (!full || pop);
    s_drop   = s_tvalid && !push;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_tdata;
    end
  end

  assign m_tvalid = !empty;
  assign m_tdata  = empty ? '0 : mem_q[rd_ptr_q];
  assign level    = level_q;

endmodule

// File: rtl/adc_decim_gain_buf.sv
// rtl/adc_decim_gain_buf.sv - ADC IQ decimator with saturating gain and output buffer
// Kept samples pass a one-stage gain register, then enter the FWFT buffer.
module adc_decim_gain_buf
  import adc_intf_pkg::*;
#(
  parameter int IQ_DATA_WIDTH = 16,
  parameter int NUM_CH        = 2,
  parameter int FIFO_DEPTH    = 32,
  parameter int OVF_CNT_WIDTH = 16
) (
  input  logic                         adc_clk,
  input  logic                         adc_rst,
  adc_decim_gain_buf_if.slave          bus,
  input  logic [1:0]                   decim_sel,
  input  logic [2:0]                   bb_gain,
  input  logic                         ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [OVF_CNT_WIDTH-1:0]     ovf_count
);

  localparam int LANES  = 2 * NUM_CH;
  localparam int DATA_W = LANES * IQ_DATA_WIDTH;
  localparam int EXT_W  = IQ_DATA_WIDTH + GAIN_SHIFT_MAX;

  localparam logic signed [EXT_W-1:0] LANE_MAX = EXT_W'(sat_max(IQ_DATA_WIDTH));
  localparam logic signed [EXT_W-1:0] LANE_MIN = EXT_W'(sat_min(IQ_DATA_WIDTH));

  logic [DECIM_CNT_WIDTH-1:0] decim_cnt_q, decim_cnt_d;
  logic                       keep;
  logic                       gain_valid_q, gain_valid_d;
  logic [DATA_W-1:0]          gain_data_q, gain_data_d;
  logic [OVF_CNT_WIDTH-1:0]   ovf_count_q, ovf_count_d;
  logic signed [EXT_W-1:0]    lane_ext;
  logic                       fifo_drop;

  // A counter left above a newly selected N-1 wraps on the next valid sample.
  always_comb begin
    decim_cnt_d = decim_cnt_q;
    keep        = 1'b0;
    if (bus.adc_valid) begin
      keep        = (decim_cnt_q == '0);
      decim_cnt_d = (decim_cnt_q >= decim_last(decim_sel)) ? '0
                                                           : decim_cnt_q + DECIM_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    gain_valid_d = keep;
    gain_data_d  = gain_data_q;
    lane_ext     = '0;
    if (keep) begin
      for (int k = 0; k < LANES; k++) begin
        lane_ext = {{GAIN_SHIFT_MAX{bus.adc_data[k*IQ_DATA_WIDTH + IQ_DATA_WIDTH - 1]}},
                    bus.adc_data[k*IQ_DATA_WIDTH +: IQ_DATA_WIDTH]};
        lane_ext = lane_ext <<< bb_gain;
        if (lane_ext > LANE_MAX) begin
          gain_data_d[k*IQ_DATA_WIDTH +: IQ_DATA_WIDTH] = LANE_MAX[IQ_DATA_WIDTH-1:0];
        end else if (lane_ext < LANE_MIN) begin
          gain_data_d[k*IQ_DATA_WIDTH +: IQ_DATA_WIDTH] = LANE_MIN[IQ_DATA_WIDTH-1:0];
        end else begin
          gain_data_d[k*IQ_DATA_WIDTH +: IQ_DATA_WIDTH] = lane_ext[IQ_DATA_WIDTH-1:0];
        end
      end
    end
  end

  // Clear wins over increment, but a drop in the clear cycle is still counted.
  always_comb begin
    ovf_count_d = ovf_count_q;
    if (ovf_clr) begin
      ovf_count_d = fifo_drop ? OVF_CNT_WIDTH'(1) : '0;
    end else if (fifo_drop && (ovf_count_q != '1)) begin
      ovf_count_d = ovf_count_q + OVF_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge adc_clk or posedge adc_rst) begin
    if (adc_rst) begin
      decim_cnt_q  <= '0;
      gain_valid_q <= 1'b0;
      gain_data_q  <= '0;
      ovf_count_q  <= '0;
    end else begin
      decim_cnt_q  <= decim_cnt_d;
      gain_valid_q <= gain_valid_d;
      gain_data_q  <= gain_data_d;
      ovf_count_q  <= ovf_count_d;
    end
  end

  adc_sync_fifo #(
    .DATA_WIDTH (DATA_W),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk      (adc_clk),
    .rst      (adc_rst),
    .s_tdata  (gain_data_q),
    .s_tvalid (gain_valid_q),
    .s_drop   (fifo_drop),
    .m_tdata  (bus.data_out),
    .m_tvalid (bus.data_out_valid),
    .m_tready (bus.data_out_ready),
    .level    (fifo_level)
  );

  assign ovf_count = ovf_count_q;

endmodule
